// File: rtl/frame_buffer_scheduler.sv
// Double-buffered frame loader feeding two BRAMs, with a fixed-priority read arbiter
// for the gradient and gamma engines. RD_LAT must be at least 3 (1 addr reg + 1 BRAM + data reg).
module frame_buffer_scheduler #(
  parameter int unsigned FRAME_WORDS = 1024,
  parameter int unsigned RD_LAT      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        grad_rd_req,
  input  logic [16:0] grad_rd_addr,
  output logic        grad_rd_gnt,
  output logic        grad_rd_valid,
  input  logic        gamma_rd_req,
  input  logic [16:0] gamma_addr_ref,
  input  logic [16:0] gamma_addr_def,
  output logic        gamma_rd_gnt,
  output logic        gamma_rd_valid,
  output logic [31:0] ref_data,
  output logic [31:0] def_data,
  output logic [31:0] bram0_addr,
  output logic [3:0]  bram0_we,
  output logic [31:0] bram0_din,
  input  logic [31:0] bram0_dout,
  output logic [31:0] bram1_addr,
  output logic [3:0]  bram1_we,
  output logic [31:0] bram1_din,
  input  logic [31:0] bram1_dout,
  output logic        proc_start,
  input  logic        proc_done,
  output logic        ref_sel,
  output logic [31:0] frame_count,
  output logic        busy
);

  localparam int unsigned WcW        = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned DataStages = RD_LAT - 2;

  typedef enum logic [1:0] {StIdle, StLoad, StProcess} state_e;

  state_e             state_q, state_d;
  logic [WcW-1:0]     wc_q;
  logic [1:0]         fill_q;  // frames loaded since reset, saturating at 2
  logic [31:0]        frame_count_q;
  logic               ref_sel_q;
  logic               proc_start_q;
  logic [RD_LAT-1:0]  grad_pipe_q, gamma_pipe_q;
  logic [31:0]        ref_pipe_q [DataStages];
  logic [31:0]        def_pipe_q [DataStages];
  logic [31:0]        addr0_q, addr1_q, din0_q, din1_q;
  logic [3:0]         we0_q, we1_q;

  logic        ld_fire, last_word, wr_sel, grad_gnt, gamma_gnt;
  logic [31:0] wc_byte, grad_byte, gref_byte, gdef_byte;

  assign ld_fire   = (state_q == StLoad) && ld_valid;
  assign last_word = (wc_q == WcW'(FRAME_WORDS - 1));
  assign grad_gnt  = (state_q == StProcess) && grad_rd_req;
  assign gamma_gnt = (state_q == StProcess) && gamma_rd_req && !grad_rd_req;
  assign wc_byte   = 32'(wc_q) << 2;
  assign grad_byte = {13'b0, grad_rd_addr, 2'b00};
  assign gref_byte = {13'b0, gamma_addr_ref, 2'b00};
  assign gdef_byte = {13'b0, gamma_addr_def, 2'b00};

  // First two frames fill BRAM0 then BRAM1; afterwards the oldest (reference) is overwritten.
  always_comb begin
    wr_sel = ref_sel_q;
    if (fill_q == 2'd0)      wr_sel = 1'b0;
    else if (fill_q == 2'd1) wr_sel = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (frame_start) state_d = StLoad;
      StLoad:    if (ld_fire && last_word) state_d = (fill_q == 2'd0) ? StIdle : StProcess;
      StProcess: if (proc_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      wc_q          <= '0;
      fill_q        <= '0;
      frame_count_q <= '0;
      ref_sel_q     <= 1'b0;
      proc_start_q  <= 1'b0;
      grad_pipe_q   <= '0;
      gamma_pipe_q  <= '0;
      addr0_q       <= '0;
      addr1_q       <= '0;
      din0_q        <= '0;
      din1_q        <= '0;
      we0_q         <= '0;
      we1_q         <= '0;
      for (int i = 0; i < int'(DataStages); i++) begin
        ref_pipe_q[i] <= '0;
        def_pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      proc_start_q <= ld_fire && last_word && (fill_q != 2'd0);
      we0_q        <= '0;
      we1_q        <= '0;

      if (ld_fire) begin
        wc_q <= last_word ? '0 : wc_q + 1'b1;
        if (wr_sel) begin
          addr1_q <= wc_byte;
          din1_q  <= ld_data;
          we1_q   <= 4'b1111;
        end else begin
          addr0_q <= wc_byte;
          din0_q  <= ld_data;
          we0_q   <= 4'b1111;
        end
        if (last_word) begin
          frame_count_q <= frame_count_q + 32'd1;
          if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
          else                ref_sel_q <= ~ref_sel_q;
        end
      end

      // Grants only occur in StProcess, so they never collide with load writes.
      if (grad_gnt) begin
        if (ref_sel_q) addr1_q <= grad_byte;
        else           addr0_q <= grad_byte;
      end else if (gamma_gnt) begin
        if (ref_sel_q) begin
          addr1_q <= gref_byte;
          addr0_q <= gdef_byte;
        end else begin
          addr0_q <= gref_byte;
          addr1_q <= gdef_byte;
        end
      end

      grad_pipe_q  <= {grad_pipe_q[RD_LAT-2:0], grad_gnt};
      gamma_pipe_q <= {gamma_pipe_q[RD_LAT-2:0], gamma_gnt};

      // BRAM dout is valid two cycles after the grant; extra latency is a plain delay line.
      if (grad_pipe_q[1] || gamma_pipe_q[1]) begin
        ref_pipe_q[0] <= ref_sel_q ? bram1_dout : bram0_dout;
        def_pipe_q[0] <= ref_sel_q ? bram0_dout : bram1_dout;
      end
      for (int i = 1; i < int'(DataStages); i++) begin
        ref_pipe_q[i] <= ref_pipe_q[i-1];
        def_pipe_q[i] <= def_pipe_q[i-1];
      end
    end
  end

  assign ld_ready       = (state_q == StLoad);
  assign grad_rd_gnt    = grad_gnt;
  assign gamma_rd_gnt   = gamma_gnt;
  assign grad_rd_valid  = grad_pipe_q[RD_LAT-1];
  assign gamma_rd_valid = gamma_pipe_q[RD_LAT-1];
  assign ref_data       = ref_pipe_q[DataStages-1];
  assign def_data       = def_pipe_q[DataStages-1];
  assign bram0_addr     = addr0_q;
  assign bram0_we       = we0_q;
  assign bram0_din      = din0_q;
  assign bram1_addr     = addr1_q;
  assign bram1_we       = we1_q;
  assign bram1_din      = din1_q;
  assign proc_start     = proc_start_q;
  assign ref_sel        = ref_sel_q;
  assign frame_count    = frame_count_q;
  assign busy           = (state_q != StIdle) || (|grad_pipe_q) || (|gamma_pipe_q);

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with behavioural 1-cycle-latency BRAMs.
module tb_frame_buffer_scheduler;

  localparam int unsigned FW = 1024;

  logic        clock, reset, frame_start, ld_valid, ld_ready;
  logic [31:0] ld_data;
  logic        grad_rd_req, grad_rd_gnt, grad_rd_valid;
  logic [16:0] grad_rd_addr, gamma_addr_ref, gamma_addr_def;
  logic        gamma_rd_req, gamma_rd_gnt, gamma_rd_valid;
  logic [31:0] ref_data, def_data;
  logic [31:0] bram0_addr, bram0_din, bram0_dout, bram1_addr, bram1_din, bram1_dout;
  logic [3:0]  bram0_we, bram1_we;
  logic        proc_start, proc_done, ref_sel, busy;
  logic [31:0] frame_count;

  int nvec = 0;
  int nerr = 0;
  int gv_cnt = 0;
  int mv_cnt = 0;

  logic [31:0] mem0 [FW];
  logic [31:0] mem1 [FW];

  frame_buffer_scheduler #(.FRAME_WORDS(FW), .RD_LAT(3)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .grad_rd_req(grad_rd_req),
    .grad_rd_addr(grad_rd_addr), .grad_rd_gnt(grad_rd_gnt), .grad_rd_valid(grad_rd_valid),
    .gamma_rd_req(gamma_rd_req), .gamma_addr_ref(gamma_addr_ref),
    .gamma_addr_def(gamma_addr_def), .gamma_rd_gnt(gamma_rd_gnt),
    .gamma_rd_valid(gamma_rd_valid), .ref_data(ref_data), .def_data(def_data),
    .bram0_addr(bram0_addr), .bram0_we(bram0_we), .bram0_din(bram0_din),
    .bram0_dout(bram0_dout), .bram1_addr(bram1_addr), .bram1_we(bram1_we),
    .bram1_din(bram1_din), .bram1_dout(bram1_dout), .proc_start(proc_start),
    .proc_done(proc_done), .ref_sel(ref_sel), .frame_count(frame_count), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bram0_we == 4'hf) mem0[bram0_addr[11:2]] <= bram0_din;
    if (bram1_we == 4'hf) mem1[bram1_addr[11:2]] <= bram1_din;
    bram0_dout <= mem0[bram0_addr[11:2]];
    bram1_dout <= mem1[bram1_addr[11:2]];
    if (grad_rd_valid)  gv_cnt <= gv_cnt + 1;
    if (gamma_rd_valid) mv_cnt <= mv_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] f(input int k, input int i);
    return 32'hA000_0000 | (32'(k) << 16) | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_grad_gnt", 32'(grad_rd_gnt), 0);
    chk("rst_gamma_gnt", 32'(gamma_rd_gnt), 0);
    chk("rst_grad_valid", 32'(grad_rd_valid), 0);
    chk("rst_gamma_valid", 32'(gamma_rd_valid), 0);
    chk("rst_proc_start", 32'(proc_start), 0);
    chk("rst_we", {24'b0, bram1_we, bram0_we}, 0);
    chk("rst_addr0", bram0_addr, 0);
    chk("rst_addr1", bram1_addr, 0);
    chk("rst_din0", bram0_din, 0);
    chk("rst_din1", bram1_din, 0);
    chk("rst_ref_data", ref_data, 0);
    chk("rst_def_data", def_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_ref_sel", 32'(ref_sel), 0);
  endtask

  // Pulses frame_start then pushes n words of frame k; checks every write lands on BRAM tgt.
  task automatic load_frame(input int k, input int n, input bit gap, input bit tgt);
    int err = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = f(k, i);
      if (ld_ready !== 1'b1 || grad_rd_gnt !== 1'b0 || gamma_rd_gnt !== 1'b0) err++;
      tick();
      if (tgt) begin
        if (bram1_we !== 4'hf || bram1_addr !== 32'(i * 4) || bram1_din !== f(k, i) ||
            bram0_we !== 4'h0) err++;
      end else begin
        if (bram0_we !== 4'hf || bram0_addr !== 32'(i * 4) || bram0_din !== f(k, i) ||
            bram1_we !== 4'h0) err++;
      end
      ld_valid = 1'b0;
      if (gap && i != n - 1) begin
        repeat (2) begin
          tick();
          if (bram0_we !== 4'h0 || bram1_we !== 4'h0) err++;
        end
      end
    end
    chk($sformatf("load_frame%0d_writes", k), 32'(err), 0);
  endtask

  typedef struct {
    logic        grq;
    logic [16:0] ga;
    logic        mrq;
    logic [16:0] mr, md;
    logic        egg, emg;
    logic [31:0] ea0, ea1;
    logic        egv, emv;
    logic [31:0] eref, edef;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int e0, e1;
    // ref_sel=1 here: BRAM1 holds frame 2 (reference), BRAM0 holds frame 3 (deformed).
    tbl[0] = '{1, 17'd9,     0, 17'd0,    17'd0, 1, 0, 32'd28, 32'd36,       1, 0, f(2, 9),    0};
    tbl[1] = '{0, 17'd0,     1, 17'd2,    17'd4, 0, 1, 32'd16, 32'd8,        0, 1, f(2, 2),    f(3, 4)};
    tbl[2] = '{0, 17'd0,     0, 17'd0,    17'd0, 0, 0, 32'd16, 32'd8,        0, 0, 0,          0};
    tbl[3] = '{1, 17'd100,   1, 17'd1,    17'd2, 1, 0, 32'd16, 32'd400,      1, 0, f(2, 100),  0};
    tbl[4] = '{1, 17'h1FFFF, 0, 17'd0,    17'd0, 1, 0, 32'd16, 32'h0007FFFC, 1, 0, f(2, 1023), 0};
    tbl[5] = '{0, 17'd0,     1, 17'd1023, 17'd0, 0, 1, 32'd0,  32'd4092,     0, 1, f(2, 1023), f(3, 0)};
    for (int i = 6; i < 9; i++)
      tbl[i] = '{0, 17'd0, 0, 17'd0, 17'd0, 0, 0, 32'd0, 32'd4092, 0, 0, 0, 0};

    reset = 1'b1; frame_start = 0; ld_valid = 0; ld_data = 0;
    grad_rd_req = 0; grad_rd_addr = 0; gamma_rd_req = 0;
    gamma_addr_ref = 0; gamma_addr_def = 0; proc_done = 0;
    tick();
    tick();
    chk_reset_outputs();
    reset = 1'b0;
    tick();

    // Requests in IDLE and during frame 1 LOAD must be dropped.
    grad_rd_req = 1'b1; gamma_rd_req = 1'b1;
    repeat (3) begin
      #1;
      chk("idle_no_gnt", {30'b0, grad_rd_gnt, gamma_rd_gnt}, 0);
      tick();
    end
    load_frame(1, FW, 1'b0, 1'b0);
    grad_rd_req = 1'b0; gamma_rd_req = 1'b0;
    chk("f1_frame_count", frame_count, 1);
    chk("f1_proc_start", 32'(proc_start), 0);
    chk("f1_ref_sel", 32'(ref_sel), 0);
    tick();
    chk("f1_idle_busy", 32'(busy), 0);
    chk("idle_load_no_valid", 32'(gv_cnt + mv_cnt), 0);

    load_frame(2, FW, 1'b0, 1'b1);
    chk("f2_proc_start", 32'(proc_start), 1);
    chk("f2_ref_sel", 32'(ref_sel), 0);
    chk("f2_frame_count", frame_count, 2);
    tick();
    chk("f2_proc_start_pulse", 32'(proc_start), 0);
    e0 = 0; e1 = 0;
    for (int i = 0; i < int'(FW); i++) begin
      if (mem0[i] !== f(1, i)) e0++;
      if (mem1[i] !== f(2, i)) e1++;
    end
    chk("bram0_holds_frame1", 32'(e0), 0);
    chk("bram1_holds_frame2", 32'(e1), 0);

    // Both requesting for 4 cycles: grad wins every cycle, results stream back-to-back.
    for (int c = 0; c < 8; c++) begin
      chk("b2b_grad_valid", 32'(grad_rd_valid), (c >= 3 && c < 7) ? 1 : 0);
      chk("b2b_gamma_valid", 32'(gamma_rd_valid), 0);
      if (c >= 3 && c < 7) chk("b2b_ref_data", ref_data, f(1, 10 + c - 3));
      grad_rd_req = (c < 4); gamma_rd_req = (c < 4); grad_rd_addr = 17'(10 + c);
      #1;
      if (c < 4) chk("b2b_gnt", {30'b0, grad_rd_gnt, gamma_rd_gnt}, 2);
      tick();
    end
    grad_rd_req = 0; gamma_rd_req = 0;

    // proc_done with a read in flight: FSM idles, read still completes.
    grad_rd_req = 1; grad_rd_addr = 17'd3;
    tick();
    grad_rd_req = 0; proc_done = 1;
    tick();
    proc_done = 0;
    chk("done_busy_inflight", 32'(busy), 1);
    chk("done_ld_ready", 32'(ld_ready), 0);
    grad_rd_req = 1;
    #1;
    chk("done_idle_no_gnt", 32'(grad_rd_gnt), 0);
    grad_rd_req = 0;
    tick();
    chk("done_valid", 32'(grad_rd_valid), 1);
    chk("done_ref_data", ref_data, f(1, 3));
    tick();
    chk("done_busy_clear", 32'(busy), 0);

    load_frame(3, FW, 1'b1, 1'b0);
    chk("f3_ref_sel", 32'(ref_sel), 1);
    chk("f3_frame_count", frame_count, 3);
    chk("f3_proc_start", 32'(proc_start), 1);
    gamma_rd_req = 1; gamma_addr_ref = 17'd5; gamma_addr_def = 17'd7;
    #1;
    chk("gamma_gnt", {30'b0, grad_rd_gnt, gamma_rd_gnt}, 1);
    tick();
    gamma_rd_req = 0;
    chk("gamma_addr1", bram1_addr, 20);
    chk("gamma_addr0", bram0_addr, 28);
    tick();
    chk("gamma_valid_early", 32'(gamma_rd_valid), 0);
    tick();
    chk("gamma_valid", 32'(gamma_rd_valid), 1);
    chk("gamma_ref_data", ref_data, f(2, 5));
    chk("gamma_def_data", def_data, f(3, 7));

    for (int k = 0; k < 9; k++) begin
      grad_rd_req = tbl[k].grq; grad_rd_addr = tbl[k].ga;
      gamma_rd_req = tbl[k].mrq; gamma_addr_ref = tbl[k].mr; gamma_addr_def = tbl[k].md;
      #1;
      chk($sformatf("tbl%0d_grad_gnt", k), 32'(grad_rd_gnt), 32'(tbl[k].egg));
      chk($sformatf("tbl%0d_gamma_gnt", k), 32'(gamma_rd_gnt), 32'(tbl[k].emg));
      tick();
      chk($sformatf("tbl%0d_addr0", k), bram0_addr, tbl[k].ea0);
      chk($sformatf("tbl%0d_addr1", k), bram1_addr, tbl[k].ea1);
      if (k >= 2) begin
        chk($sformatf("tbl%0d_grad_valid", k - 2), 32'(grad_rd_valid), 32'(tbl[k-2].egv));
        chk($sformatf("tbl%0d_gamma_valid", k - 2), 32'(gamma_rd_valid), 32'(tbl[k-2].emv));
        if (tbl[k-2].egv || tbl[k-2].emv)
          chk($sformatf("tbl%0d_ref_data", k - 2), ref_data, tbl[k-2].eref);
        if (tbl[k-2].emv)
          chk($sformatf("tbl%0d_def_data", k - 2), def_data, tbl[k-2].edef);
      end
    end
    grad_rd_req = 0; gamma_rd_req = 0;

    // Reset with a read in flight: no valid may emerge afterwards.
    grad_rd_req = 1; grad_rd_addr = 17'd1;
    tick();
    grad_rd_req = 0; reset = 1;
    tick();
    chk_reset_outputs();
    reset = 0;
    repeat (4) begin
      tick();
      chk("rst_inflight_dropped", 32'(grad_rd_valid), 0);
    end

    // Reset at wc=500 of the second frame; next frame must restart in BRAM0.
    load_frame(4, FW, 1'b0, 1'b0);
    tick();
    load_frame(5, 500, 1'b0, 1'b1);
    reset = 1;
    tick();
    chk_reset_outputs();
    reset = 0;
    tick();
    load_frame(6, FW, 1'b0, 1'b0);
    chk("post_rst_frame_count", frame_count, 1);
    chk("post_rst_proc_start", 32'(proc_start), 0);
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_bram0_last", mem0[FW-1], f(6, FW - 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
